// File: rtl/serial_crc_pkg.sv
// Shared types and CRC-8 defaults for the bit-serial CRC engine.
package serial_crc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } crc_state_t;

  localparam logic [7:0] CRC8_POLY   = 8'h07;
  localparam logic [7:0] CRC8_INIT   = 8'h00;
  localparam logic [7:0] CRC8_XOROUT = 8'h55;

endpackage : serial_crc_pkg

// File: rtl/serial_crc_step.sv
// Combinational single-bit LFSR update: shifts the CRC left by one and folds in the polynomial.
module crc_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] crc_in,
  input  logic             data_bit,
  input  logic [WIDTH-1:0] poly,
  output logic [WIDTH-1:0] crc_next
);

  logic fb;

  assign fb       = crc_in[WIDTH-1] ^ data_bit;
  assign crc_next = {crc_in[WIDTH-2:0], 1'b0} ^ (fb ? poly : '0);

endmodule : crc_step

// File: rtl/serial_crc.sv
// Bit-serial CRC engine with a valid/ready result port.
// Define SERIAL_CRC_XOROUT_EN to apply the XOR_OUT mask to the presented CRC.
module serial_crc
  import serial_crc_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] POLY    = CRC8_POLY,
  parameter logic [WIDTH-1:0] INIT    = CRC8_INIT,
  parameter logic [WIDTH-1:0] XOR_OUT = CRC8_XOROUT,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             in_last,
  output logic             crc_valid,
  input  logic             crc_ready,
  output logic [WIDTH-1:0] crc_out,
  output logic [CNT_W-1:0] frame_len
);

`ifdef SERIAL_CRC_XOROUT_EN
  localparam logic [WIDTH-1:0] OUT_MASK = XOR_OUT;
`else
  // Mask forced to zero; XOR_OUT stays referenced so both builds share one parameter list.
  localparam logic [WIDTH-1:0] OUT_MASK = XOR_OUT & '0;
`endif

  crc_state_t       state_q, state_d;
  logic [WIDTH-1:0] crc_q, crc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             crc_valid_q, crc_valid_d;
  logic [WIDTH-1:0] crc_out_q, crc_out_d;
  logic [CNT_W-1:0] frame_len_q, frame_len_d;

  logic [WIDTH-1:0] crc_stepped;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic             handoff;

  crc_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .crc_in  (crc_q),
    .data_bit(in_bit),
    .poly    (POLY),
    .crc_next(crc_stepped)
  );

  assign accept  = in_valid & in_ready_q;
  assign handoff = crc_valid_q & crc_ready;
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    crc_valid_d = crc_valid_q;
    crc_out_d   = crc_out_q;
    frame_len_d = frame_len_q;

    if (clr) begin
      // Abort wins over any simultaneous accept or handoff.
      state_d     = IDLE;
      crc_d       = INIT;
      cnt_d       = '0;
      crc_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, BUSY: begin
          if (accept) begin
            crc_d = crc_stepped;
            cnt_d = cnt_inc;
            if (in_last) begin
              state_d     = DONE;
              crc_valid_d = 1'b1;
              crc_out_d   = crc_stepped ^ OUT_MASK;
              frame_len_d = cnt_inc;
            end else begin
              state_d = BUSY;
            end
          end
        end
        DONE: begin
          if (handoff) begin
            state_d     = IDLE;
            crc_d       = INIT;
            cnt_d       = '0;
            crc_valid_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Registered so in_ready stays low while in reset and never follows in_valid.
    in_ready_d = (state_d != DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      crc_q       <= INIT;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      crc_valid_q <= 1'b0;
      crc_out_q   <= INIT;
      frame_len_q <= '0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      crc_valid_q <= crc_valid_d;
      crc_out_q   <= crc_out_d;
      frame_len_q <= frame_len_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign crc_valid = crc_valid_q;
  assign crc_out   = crc_out_q;
  assign frame_len = frame_len_q;

endmodule : serial_crc

// File: tb/tb_serial_crc.sv
// Self-checking bench for serial_crc: polynomial long-division model plus directed frames.
module tb_serial_crc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_bit = 1'b0;
  logic       in_last = 1'b0;
  logic       crc_valid;
  logic       crc_ready = 1'b0;
  logic [7:0] crc_out;
  logic [7:0] frame_len;

`ifdef SERIAL_CRC_XOROUT_EN
  localparam logic [7:0] MASK = 8'h55;
`else
  localparam logic [7:0] MASK = 8'h00;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  bit         frame_q[$];
  logic       exp_pending = 1'b0;
  logic [7:0] exp_crc = 8'h00;
  logic [7:0] exp_len = 8'h00;

  serial_crc dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_bit   (in_bit),
    .in_last  (in_last),
    .crc_valid(crc_valid),
    .crc_ready(crc_ready),
    .crc_out  (crc_out),
    .frame_len(frame_len)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Remainder of M(x)*x^8 divided by x^8+x^2+x+1, computed by long division on a bit array.
  function automatic logic [7:0] model_crc();
    int         n = frame_q.size();
    bit         r[];
    logic [8:0] p = 9'h107;
    logic [7:0] res;
    r = new[n + 8];
    for (int i = 0; i < n + 8; i++) r[i] = (i < n) ? frame_q[i] : 1'b0;
    for (int i = 0; i < n; i++)
      if (r[i]) for (int j = 0; j <= 8; j++) r[i+j] = r[i+j] ^ p[8-j];
    for (int k = 0; k < 8; k++) res[7-k] = r[n+k];
    return res;
  endfunction

  function automatic void add_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) frame_q.push_back(b[i]);
  endfunction

  // Called at a negedge; presents one beat and returns at the negedge after it is accepted.
  task automatic drive_bit(input bit b, input bit last, input bit with_clr);
    int t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("ready_timeout", 32'd0, 32'd1);
    in_valid = 1'b1;
    in_bit   = b;
    in_last  = last;
    clr      = with_clr;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic send_frame();
    int n = frame_q.size();
    for (int i = 0; i < n; i++) drive_bit(frame_q[i], i == n - 1, 1'b0);
    exp_crc     = model_crc() ^ MASK;
    exp_len     = (n > 255) ? 8'd255 : 8'(n);
    exp_pending = 1'b1;
    check("latency_valid", 32'(crc_valid), 32'd1);
  endtask

  // Holds the result for hold cycles, then hands it off and checks the return to IDLE.
  task automatic take_result(input string name, input logic [7:0] lit_crc, input logic [7:0] lit_len,
                             input int hold);
    check({name, "_crc"}, 32'(crc_out), 32'(lit_crc ^ MASK));
    check({name, "_len"}, 32'(frame_len), 32'(lit_len));
    $display("frame %s: crc_out=0x%02h frame_len=%0d", name, crc_out, frame_len);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, "_hold_crc"}, 32'(crc_out), 32'(lit_crc ^ MASK));
      check({name, "_hold_len"}, 32'(frame_len), 32'(lit_len));
      check({name, "_hold_ready"}, 32'(in_ready), 32'd0);
    end
    crc_ready = 1'b1;
    @(negedge clk);
    crc_ready   = 1'b0;
    exp_pending = 1'b0;
    check({name, "_after_valid"}, 32'(crc_valid), 32'd0);
    check({name, "_after_ready"}, 32'(in_ready), 32'd1);
    frame_q.delete();
  endtask

  // Compare process: runs shortly after every falling edge, once the driver has settled.
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_crc_valid", 32'(crc_valid), 32'd0);
    end else begin
      check("cyc_valid", 32'(crc_valid), 32'(exp_pending));
      if (exp_pending && crc_valid) begin
        check("cyc_crc", 32'(crc_out), 32'(exp_crc));
        check("cyc_len", 32'(frame_len), 32'(exp_len));
      end
    end
  end

  initial begin
    // Pin the model with known CRC-8 values.
    add_byte(8'h80); check("model_80", 32'(model_crc()), 32'h89); frame_q.delete();
    add_byte(8'h01); check("model_01", 32'(model_crc()), 32'h07); frame_q.delete();
    for (int i = 0; i < 9; i++) add_byte(8'h31 + 8'(i));
    check("model_check", 32'(model_crc()), 32'hF4); frame_q.delete();

    repeat (3) @(negedge clk);
    check("reset_out", 32'(crc_out), 32'h00);
    check("reset_len", 32'(frame_len), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-frame, then a clean frame starts from INIT.
    for (int i = 0; i < 5; i++) drive_bit(1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_ready", 32'(in_ready), 32'd1);
    add_byte(8'h01); send_frame(); take_result("after_rst_01", 8'h07, 8'd8, 0);

    add_byte(8'h80); send_frame(); take_result("byte_80", 8'h89, 8'd8, 0);
    add_byte(8'h01); send_frame(); take_result("byte_01", 8'h07, 8'd8, 0);

    for (int i = 0; i < 9; i++) add_byte(8'h31 + 8'(i));
    send_frame(); take_result("ascii_123456789", 8'hF4, 8'd72, 0);

    add_byte(8'hC3); send_frame(); take_result("backpressure_C3", model_crc(), 8'd8, 10);

    // clr together with a last beat mid-frame discards the frame.
    for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b0, 1'b0);
    drive_bit(1'b0, 1'b1, 1'b1);
    repeat (2) begin
      check("clr_no_valid", 32'(crc_valid), 32'd0);
      check("clr_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
    end
    add_byte(8'h01); send_frame(); take_result("after_clr_01", 8'h07, 8'd8, 0);

    for (int i = 0; i < 300; i++) frame_q.push_back(1'b0);
    send_frame(); take_result("zeros_300", 8'h00, 8'd255, 0);

    frame_q.push_back(1'b1);
    send_frame(); take_result("single_one", 8'h07, 8'd1, 0);

    repeat (2) @(negedge clk);
    #3;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule : tb_serial_crc
